// File: rtl/spi_reg_bridge.sv
// Bridges decoded SPI transactions from spi_data_path onto the accelerator register bus.
// Single outstanding bus cycle; supports auto-increment bursts, bus timeout and sticky errors.
module spi_reg_bridge #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              address_ready,
    input  logic              data_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        status,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cs_n_o,
    input  logic              miso_start,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic              err_clr,
    output logic [2:0]        err_flags,
    output logic              busy
);

    localparam int unsigned       CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ErrWord = DATA_W'(16'hDEAD);

    typedef enum logic [2:0] {
        StIdle,
        StWaitWdata,
        StWrReq,
        StRdReq,
        StRdHold,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              auto_inc_q, auto_inc_d;
    logic              abort_q, abort_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        err_q, err_d, err_set;
    logic              in_req, timed_out, done;

    assign in_req    = (state_q == StWrReq) || (state_q == StRdReq);
    assign timed_out = in_req && !bus_ack && !bus_err && (cnt_q == CntLast);
    assign done      = in_req && (bus_ack || bus_err || timed_out);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        auto_inc_d = auto_inc_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_set    = 3'b000;
        cnt_d      = (in_req && !done) ? cnt_q + 1'b1 : '0;
        // Remember a deselect seen mid-cycle so the request still runs to completion.
        abort_d    = in_req && !done && (abort_q || cs_n_o);

        if (in_req && bus_err) err_set[1] = 1'b1;
        if (timed_out)         err_set[0] = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (!cs_n_o && address_ready) begin
                    cur_addr_d = addr;
                    auto_inc_d = status[1];
                    if (status[3:2] != 2'b00) begin
                        err_set[2] = 1'b1;
                        state_d    = StDone;
                    end else if (status[0]) begin
                        state_d = StRdReq;
                    end else begin
                        state_d = StWaitWdata;
                    end
                end
            end
            StWaitWdata: begin
                if (cs_n_o) begin
                    state_d = StIdle;
                end else if (data_ready) begin
                    wdata_d = wdata;
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                if (data_ready && !cs_n_o) err_set[2] = 1'b1;
                if (done) begin
                    if (auto_inc_q) cur_addr_d = cur_addr_q + 1'b1;
                    if (abort_q || cs_n_o) state_d = StIdle;
                    else                   state_d = auto_inc_q ? StWaitWdata : StDone;
                end
            end
            StRdReq: begin
                if (done) begin
                    rdata_d = (bus_ack && !bus_err) ? bus_rdata : ErrWord;
                    state_d = (abort_q || cs_n_o) ? StIdle : StRdHold;
                end
            end
            StRdHold: begin
                if (cs_n_o) begin
                    state_d = StIdle;
                end else if (miso_start && auto_inc_q) begin
                    cur_addr_d = cur_addr_q + 1'b1;
                    state_d    = StRdReq;
                end
            end
            StDone: begin
                if (cs_n_o) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        err_d = (err_clr ? 3'b000 : err_q) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            auto_inc_q <= 1'b0;
            abort_q    <= 1'b0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            auto_inc_q <= auto_inc_d;
            abort_q    <= abort_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus_req   = in_req;
    assign bus_we    = (state_q == StWrReq);
    assign bus_addr  = cur_addr_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err_flags = err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Downstream stage of `spi_data_path`: consumes its decoded address/command (`addr`, `status`, `address_ready`) and write words (`wdata`, `data_ready`), and turns them into single-outstanding read/write cycles on the accelerator register bus. Read data is returned to the data path on `rdata`. The block supports single and auto-increment burst transfers, a bus timeout, and sticky error flags.

## Interface
- `ADDR_W`, 20, address width (matches `addr`)
- `DATA_W`, 16, data word width
- `TIMEOUT`, 255, max cycles `bus_req` waits for `bus_ack`/`bus_err`
- `clk`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `address_ready`  in  1  1-cycle pulse; `addr`, `status` valid
- `data_ready`  in  1  1-cycle pulse; `wdata` valid
- `addr`  in  ADDR_W  start address of transaction
- `status`  in  4  command: [0]=1 read/0 write, [1]=auto-increment, [3:2] must be 00
- `wdata`  in  DATA_W  write word from data path
- `cs_n_o`  in  1  chip select from data path (clk domain); 1 = transaction ended
- `miso_start`  in  1  1-cycle pulse; data path has loaded `rdata` for shifting
- `rdata`  out  DATA_W  read word to data path
- `bus_req`  out  1  bus cycle request
- `bus_we`  out  1  1 = write cycle
- `bus_addr`  out  ADDR_W  bus address
- `bus_wdata`  out  DATA_W  bus write data
- `bus_rdata`  in  DATA_W  bus read data, valid with `bus_ack`
- `bus_ack`  in  1  1-cycle completion pulse
- `bus_err`  in  1  1-cycle error completion pulse
- `err_clr`  in  1  clears `err_flags`
- `err_flags`  out  3  sticky: [0] timeout, [1] bus error, [2] command error/overrun
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, WAIT_WDATA, WR_REQ, RD_REQ, RD_HOLD, DONE.
- IDLE: on `address_ready` with `cs_n_o`=0, latch `addr` into `cur_addr` and `status[1:0]`. If `status[3:2]`!=0, set `err_flags[2]` and go to DONE. Otherwise a read goes to RD_REQ; a write goes to WAIT_WDATA.
- WAIT_WDATA: on `data_ready`, latch `wdata` into `bus_wdata` and go to WR_REQ.
- WR_REQ: `bus_req`=1, `bus_we`=1 until completion.
  - Completion with auto-increment: `cur_addr`+1, then WAIT_WDATA.
  - Completion without auto-increment: DONE.
- RD_REQ: `bus_req`=1, `bus_we`=0. On `bus_ack`, `rdata`<=`bus_rdata`, then RD_HOLD.
- RD_HOLD: on `miso_start` with auto-increment, `cur_addr`+1 and go to RD_REQ (prefetch). Without auto-increment, stay.
- DONE: ignore `address_ready` and `data_ready`; wait for `cs_n_o`.
- Completion is `bus_ack`, `bus_err`, or timeout.
  - `bus_err`: sets `err_flags[1]`.
  - Timeout (`TIMEOUT` cycles of `bus_req` with no response): sets `err_flags[0]`.
  - On a read, `bus_err` or timeout loads `rdata`<=16'hDEAD.
  - The next state after `bus_err` or timeout is the same as after `bus_ack`.
- `cs_n_o`=1:
  - In IDLE, WAIT_WDATA, RD_HOLD or DONE: go to IDLE the next cycle.
  - In WR_REQ or RD_REQ: the current bus cycle runs to completion first, then the block goes to IDLE. A request is never dropped.
- `cs_n_o`=1 wins over a simultaneous `address_ready` or `data_ready`.
- `data_ready` while in WR_REQ (overrun): the word is dropped and `err_flags[2]` is set.
- `cur_addr` wraps from 2^ADDR_W-1 to 0.
- `err_flags` set and `err_clr` in the same cycle: set wins.
- `bus_ack` and `bus_err` in the same cycle: treated as `bus_err`.
- `bus_ack`/`bus_err` while `bus_req`=0: ignored.

## Timing
- Reset: state IDLE; `rdata`, `bus_addr`, `bus_wdata` = 0; `bus_req`, `bus_we`, `busy`, `err_flags` = 0; timeout counter = 0.
- `address_ready` (read) at cycle N: `bus_req`=1 at N+1.
- `data_ready` at cycle N: `bus_req`=1 at N+1.
- `bus_addr`, `bus_we`, `bus_wdata` are stable for the whole time `bus_req`=1.
- Completion at cycle M: `bus_req`=0 and `rdata` updated at M+1.
- `bus_req` is low for at least one cycle between consecutive bus cycles.
- Timeout counter starts at 0 on the first `bus_req` cycle. With no response, the request ends after exactly `TIMEOUT` cycles of `bus_req`=1.
- Burst prefetch: `miso_start` at cycle N means `bus_req`=1 at N+1 with the incremented address.
- `busy` is registered and follows the state.

## Test plan
- Single write: `address_ready`, addr=20'h00010, status=4'b0000; `data_ready`, wdata=16'hC69A; ack 2 cycles after req -> one bus cycle, addr 20'h00010, data C69A, we=1; second `data_ready` ignored; IDLE after `cs_n_o`=1.
- Burst read: addr=20'hFFFFE, status=4'b0011; `bus_rdata`=16'h1111, 16'h2222, 16'h3333, with `miso_start` after each -> `bus_addr` FFFFE, FFFFF, 00000 (wrap); `rdata` follows the three values.
- Timeout: read, no ack, TIMEOUT=255 -> `bus_req` high exactly 255 cycles, `rdata`=16'hDEAD, `err_flags`=3'b001; `err_clr` -> 3'b000.
- Abort mid-cycle: `cs_n_o`=1 during WR_REQ, ack 5 cycles later -> `bus_req` held until ack, then IDLE; no further bus cycles.
- Errors: status=4'b0100 -> no `bus_req`, `err_flags[2]`=1; `bus_err` on a read -> `rdata`=16'hDEAD, `err_flags[1]`=1; overrun `data_ready` during WR_REQ -> word dropped, `err_flags[2]`=1.
- Reset mid-burst: `reset_n`=0 during RD_REQ -> next cycle all outputs at reset values, state IDLE.
